// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider widths, iteration count and FSM states.
package arith_pkg;

    localparam int unsigned DIV_N_W   = 8;
    localparam int unsigned DIV_D_W   = 4;
    localparam int unsigned DIV_ITER  = 8;
    localparam int unsigned DIV_CNT_W = 3;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: T = {R, bit}; subtract the divisor if it fits, else restore T.
module div_step
    import arith_pkg::*;
(
    input  logic [DIV_D_W-1:0] i_r,
    input  logic               i_bit,
    input  logic [DIV_D_W-1:0] i_divisor,
    output logic [DIV_D_W:0]   o_r,
    output logic               o_qbit
);

    logic [DIV_D_W:0]   w_t;
    logic [DIV_D_W:0]   w_dinv;
    logic [DIV_D_W:0]   w_diff;
    logic [DIV_D_W+1:0] w_carry;

    assign w_t        = {i_r, i_bit};
    assign w_dinv     = ~{1'b0, i_divisor};
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g <= DIV_D_W; g++) begin : g_sub
        full_adder u_fa (
            .i_a  (w_t[g]),
            .i_b  (w_dinv[g]),
            .i_ci (w_carry[g]),
            .o_s  (w_diff[g]),
            .o_co (w_carry[g+1])
        );
    end

    // Carry-out of T + ~D + 1 means no borrow, i.e. T >= divisor.
    assign o_qbit = w_carry[DIV_D_W+1];
    assign o_r    = o_qbit ? w_diff : w_t;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell shared across the arithmetic datapath.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential 8/4 unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVIDER_DBZ_EN to short-circuit divide-by-zero and raise dbz.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH_N = DIV_N_W,
    parameter int unsigned WIDTH_D = DIV_D_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               dbz
);

    div_state_t           r_state;
    div_state_t           w_state_nxt;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [WIDTH_N-1:0]   r_q;
    logic [WIDTH_D:0]     r_part;
    logic [WIDTH_D-1:0]   r_divisor;
    logic [WIDTH_N-1:0]   r_quot;
    logic [WIDTH_D-1:0]   r_rem;
    logic [WIDTH_D:0]     w_r_next;
    logic                 w_qbit;
    logic                 w_accept;
    logic                 w_go_run;
    logic                 w_last;
    logic                 w_unused;

`ifdef DIVIDER_DBZ_EN
    logic r_dbz;
    logic r_dbz_pend;
    logic w_go_dbz;

    // A pending zero-divisor request spends one non-busy cycle in IDLE before DONE.
    assign w_accept = start && !r_dbz_pend && (r_state == DIV_IDLE || r_state == DIV_DONE);
    assign w_go_run = w_accept && (divisor != '0);
    assign w_go_dbz = w_accept && (divisor == '0);
    assign dbz      = r_dbz;
`else
    assign w_accept = start && (r_state == DIV_IDLE || r_state == DIV_DONE);
    assign w_go_run = w_accept;
    assign dbz      = 1'b0;
`endif

    assign w_last = (r_cnt == '0);
    // Bit 4 of R never feeds the next T; it only carries the restored top bit.
    assign w_unused = r_part[WIDTH_D];

    div_step u_step (
        .i_r       (r_part[WIDTH_D-1:0]),
        .i_bit     (r_q[WIDTH_N-1]),
        .i_divisor (r_divisor),
        .o_r       (w_r_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DIV_IDLE: begin
                if (w_go_run) begin
                    w_state_nxt = DIV_RUN;
                end
`ifdef DIVIDER_DBZ_EN
                else if (r_dbz_pend) begin
                    w_state_nxt = DIV_DONE;
                end
`endif
            end
            DIV_RUN: begin
                if (w_last) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_state_nxt = w_go_run ? DIV_RUN : DIV_IDLE;
            end
            default: begin
                w_state_nxt = DIV_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == DIV_RUN);
        done = (r_state == DIV_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_part    <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
`ifdef DIVIDER_DBZ_EN
            r_dbz      <= 1'b0;
            r_dbz_pend <= 1'b0;
`endif
        end else begin
            if (w_go_run) begin
                r_q       <= dividend;
                r_part    <= '0;
                r_cnt     <= DIV_CNT_W'(DIV_ITER - 1);
                r_divisor <= divisor;
            end
`ifdef DIVIDER_DBZ_EN
            else if (w_go_dbz) begin
                r_q        <= dividend;
                r_part     <= '0;
                r_dbz_pend <= 1'b1;
            end else if (r_state == DIV_IDLE && r_dbz_pend) begin
                r_quot     <= '1;
                r_rem      <= r_q[WIDTH_D-1:0];
                r_dbz      <= 1'b1;
                r_dbz_pend <= 1'b0;
            end
`endif
            else if (r_state == DIV_RUN) begin
                r_q    <= {r_q[WIDTH_N-2:0], w_qbit};
                r_part <= w_r_next;
                r_cnt  <= r_cnt - 1'b1;
                if (w_last) begin
                    r_quot <= {r_q[WIDTH_N-2:0], w_qbit};
                    r_rem  <= w_r_next[WIDTH_D-1:0];
`ifdef DIVIDER_DBZ_EN
                    r_dbz  <= 1'b0;
`endif
                end
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed cases, random ops and a full operand sweep.
module tb_seq_restoring_divider;

`ifdef DIVIDER_DBZ_EN
    localparam bit DBZ_MODE = 1'b1;
`else
    localparam bit DBZ_MODE = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        q_exp[$];
    logic [7:0]  hold_q = '0;
    logic [3:0]  hold_r = '0;
    logic        hold_z = 1'b0;

    seq_restoring_divider #(.WIDTH_N(8), .WIDTH_D(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t ref_div(input int unsigned a, input int unsigned b);
        exp_t e;
        if (b == 0) begin
            e.q = 8'hFF;
            e.r = 4'(a % 16);
            e.z = DBZ_MODE;
        end else begin
            e.q = 8'(a / b);
            e.r = 4'(a % b);
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks outputs hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_q = '0;
            hold_r = '0;
            hold_z = 1'b0;
        end else begin
            check("busy_done_exclusive", int'(busy && done), 0);
            if (done) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("dbz", dbz, e.z);
                    hold_q = e.q;
                    hold_r = e.r;
                    hold_z = e.z;
                end
            end else begin
                check("hold_quotient", quotient, hold_q);
                check("hold_remainder", remainder, hold_r);
                check("hold_dbz", dbz, hold_z);
            end
        end
    end

    task automatic idle(input int unsigned n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issues one op; optionally pulses a second start at RUN-relative cycle intr_j.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int intr_j,
                          input logic [7:0] ia, input logic [3:0] ib);
        exp_t        e;
        int unsigned exp_lat;
        int unsigned j;
        bit          busy_ok;
        bit          seen;
        e       = ref_div(a, b);
        exp_lat = e.z ? 1 : 8;
        busy_ok = 1'b1;
        seen    = 1'b0;
        j       = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        q_exp.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        while (j < 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy !== !e.z) busy_ok = 1'b0;
            if (int'(j) == intr_j) begin
                start    = 1'b1;
                dividend = ia;
                divisor  = ib;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", j, exp_lat);
        check("busy_window", busy_ok, 1);
    endtask

    initial begin
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", dbz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        run_op(8'd200, 4'd7, -1, '0, '0);
        idle(1);
        run_op(8'd255, 4'd1, -1, '0, '0);
        run_op(8'd13, 4'd15, -1, '0, '0);
        idle(2);
        run_op(8'hA5, 4'd0, -1, '0, '0);
        idle(1);
        run_op(8'd100, 4'd9, 3, 8'd50, 4'd3);
        idle(2);

        // Asynchronous reset in the 5th RUN cycle discards the op.
        dividend = 8'd77;
        divisor  = 4'd6;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_quotient", quotient, 0);
        check("midrun_reset_remainder", remainder, 0);
        check("midrun_reset_dbz", dbz, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        run_op(8'd77, 4'd6, -1, '0, '0);
        idle(1);

        for (int i = 0; i < 200; i++) begin
            run_op(8'($urandom), 4'($urandom), -1, '0, '0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(8'(a), 4'(b), -1, '0, '0);
                if ($urandom_range(0, 7) == 0) idle(1);
            end
        end

        idle(3);
        check("scoreboard_drained", q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
